// File: rtl/rv32i_insn_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_insn_encoder
// Description : Two-stage RV32I instruction word encoder with range/alignment
//               checking, valid/ready handshake and saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_insn_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_imm_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_err,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_err
);

    localparam logic [2:0]  C_FMT_I     = 3'b000;
    localparam logic [2:0]  C_FMT_S     = 3'b001;
    localparam logic [2:0]  C_FMT_B     = 3'b010;
    localparam logic [2:0]  C_FMT_U     = 3'b011;
    localparam logic [2:0]  C_FMT_J     = 3'b100;
    localparam logic [2:0]  C_FMT_R     = 3'b101;
    localparam logic [1:0]  C_ERR_OK    = 2'b00;
    localparam logic [1:0]  C_ERR_RANGE = 2'b01;
    localparam logic [1:0]  C_ERR_ALIGN = 2'b10;
    localparam logic [1:0]  C_ERR_FMT   = 2'b11;
    localparam logic [15:0] C_CNT_MAX   = 16'hFFFF;

    logic        r_s1_valid;
    logic [31:0] r_s1_instr;
    logic [1:0]  r_s1_err;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [1:0]  r_out_err;
    logic [15:0] r_cnt_ok;
    logic [15:0] r_cnt_err;

    logic        w_range;
    logic        w_align;
    logic        w_illegal;
    logic [1:0]  w_err;
    logic [31:0] w_packed;
    logic [31:0] w_instr;
    logic        w_s2_load;
    logic        w_accept;
    logic        w_deliver;

    // A field is in range when all bits above the encodable width are sign copies.
    always_comb begin
        w_range = 1'b0;
        case (in_imm_fmt)
            C_FMT_I, C_FMT_S: w_range = !((&in_imm[31:11]) || (~|in_imm[31:11]));
            C_FMT_B:          w_range = !((&in_imm[31:12]) || (~|in_imm[31:12]));
            C_FMT_J:          w_range = !((&in_imm[31:20]) || (~|in_imm[31:20]));
            C_FMT_U:          w_range = |in_imm[11:0];
            default:          w_range = 1'b0;
        endcase
    end

    assign w_align   = ((in_imm_fmt == C_FMT_B) || (in_imm_fmt == C_FMT_J)) && in_imm[0];
    assign w_illegal = in_imm_fmt[2] && in_imm_fmt[1];

    always_comb begin
        w_err = C_ERR_OK;
        if (w_illegal) begin
            w_err = C_ERR_FMT;
        end else if (w_align) begin
            w_err = C_ERR_ALIGN;
        end else if (w_range) begin
            w_err = C_ERR_RANGE;
        end
    end

    always_comb begin
        w_packed = 32'h0;
        case (in_imm_fmt)
            C_FMT_R: w_packed = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            C_FMT_I: w_packed = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            C_FMT_S: w_packed = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            C_FMT_B: w_packed = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
            C_FMT_U: w_packed = {in_imm[31:12], in_rd, in_opcode};
            C_FMT_J: w_packed = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, in_opcode};
            default: w_packed = 32'h0;
        endcase
    end

    assign w_instr   = (w_err == C_ERR_OK) ? w_packed : 32'h0;

    assign w_s2_load = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_instr  <= 32'h0;
            r_s1_err    <= C_ERR_OK;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
            r_out_err   <= C_ERR_OK;
            r_cnt_ok    <= 16'h0;
            r_cnt_err   <= 16'h0;
        end else begin
            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
                r_out_instr <= r_s1_instr;
                r_out_err   <= r_s1_err;
            end
            // A fresh accept refills S1 even while its old word moves into S2.
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_instr <= w_instr;
                r_s1_err   <= w_err;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_deliver) begin
                if (r_out_err == C_ERR_OK) begin
                    if (r_cnt_ok != C_CNT_MAX) begin
                        r_cnt_ok <= r_cnt_ok + 16'd1;
                    end
                end else begin
                    if (r_cnt_err != C_CNT_MAX) begin
                        r_cnt_err <= r_cnt_err + 16'd1;
                    end
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign cnt_ok    = r_cnt_ok;
    assign cnt_err   = r_cnt_err;

endmodule
`default_nettype wire

// File: doc/rv32i_insn_encoder.md
RV32I_INSN_ENCODER -- requirements
Module: rv32i_insn_encoder

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_imm_fmt  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 R; 110/111 illegal
- in_opcode  in  7  instr[6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  two's-complement byte offset/immediate
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer ready
- out_instr  out  32  encoded instruction
- out_err  out  2  00 ok, 01 range, 10 misaligned, 11 illegal fmt
- cnt_ok  out  16  saturating count of ok words delivered
- cnt_err  out  16  saturating count of error words delivered

Function
REQ-003 SHALL be a 2-stage pipeline: S1 captures request and computes out_err; S2 (output register) holds packed out_instr/out_err.
REQ-004 SHALL have latency 2 cycles: request accepted at edge N appears on out_valid after edge N+1, with no backpressure.
REQ-005 SHALL have throughput 1 word/cycle when out_ready=1.
REQ-006 Stage advance rules:
- S2 loads when it is empty or out_valid&&out_ready.
- S1 advances under the same condition.
- in_ready = !S1_valid || S2 loads; in_ready is combinational from registered state and out_ready only.
REQ-007 SHALL hold out_valid, out_instr and out_err stable while out_valid&&!out_ready, and SHALL never drop, duplicate or reorder requests.
REQ-008 Field packing for ok words:
- R: funct7|rs2|rs1|funct3|rd|opcode
- I: imm[11:0]|rs1|funct3|rd|opcode
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
- U: imm[31:12]|rd|opcode
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
REQ-009 Unused fields for a format (e.g. rd for S/B, in_imm for R) SHALL be ignored.
REQ-010 Range rules (error 01):
- I/S: in_imm[31:11] not all equal
- B: in_imm[31:12] not all equal
- J: in_imm[31:20] not all equal
- U: in_imm[11:0]!=0
REQ-011 Alignment rule (error 10): in_imm[0]=1 for B or J.
REQ-012 Error priority SHALL be 11 > 10 > 01.
REQ-013 Any error word SHALL carry out_instr=32'h0 and still be delivered via the handshake.
REQ-014 On each out_valid&&out_ready, exactly one of cnt_ok (out_err=00) or cnt_err increments; each counter saturates at 16'hFFFF.

Reset
REQ-015 While rst=1 at a rising edge:
- S1/S2 valid cleared; out_valid=0, out_instr=0, out_err=0, cnt_ok=0, cnt_err=0.
- Inputs are ignored and no request is accepted that cycle.
REQ-016 Reset mid-operation SHALL discard all in-flight words without delivering them; in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-017 ADDI: fmt I, opcode 0x13, rd 1, rs1 0, funct3 0, imm 0xFFFFFFFF -> out_instr 0xFFF00093, err 00, out_valid 2 cycles after accept, cnt_ok=1.
REQ-018 BEQ: fmt B, opcode 0x63, rs1 1, rs2 2, funct3 0, imm 8 -> out_instr 0x00208463, err 00.
REQ-019 Error cases:
- fmt B imm 7 -> err 10, instr 0, cnt_err=1.
- fmt I imm 2048 -> err 01.
- fmt 110 with imm 7 -> err 11.
REQ-020 Backpressure: out_ready=0 for 4 cycles while 3 back-to-back requests are offered -> in_ready drops after 2 accepted; all 3 are delivered in order after out_ready=1, and out_instr is stable while stalled.
REQ-021 Reset with both stages full -> next cycle out_valid=0, counters 0, in_ready=1; no stale word is delivered afterwards.
REQ-022 Saturation: preload via 65 540 ok handshakes -> cnt_ok=0xFFFF and holds; cnt_err remains unchanged.
